// File: rtl/fetch_queue.sv
// Fetch-to-Decode instruction queue: DEPTH x {pc, instr, exc, bd}, program order, one-cycle flush.
// Latency: push in cycle N is visible at pop_* in cycle N+1 (same cycle on an empty queue when FQ_BYPASS_EN is defined).
// Backpressure: push_ready = not full, independent of pop_ready (no write-through when full); pop_ready low holds the head.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [31:0]   push_pc,
  input  logic [31:0]   push_instr,
  input  logic [4:0]    push_exc,
  input  logic          push_bd,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [31:0]   pop_pc,
  output logic [31:0]   pop_instr,
  output logic [4:0]    pop_exc,
  output logic          pop_bd,
  output logic [AW:0]   count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic   not_empty;
  logic   push_fire;
  logic   pop_fire;
  logic   wr_en;
  logic   byp;
  entry_t push_entry;

  assign not_empty  = (count != '0);
  assign push_ready = (count != (AW+1)'(DEPTH));
  assign push_fire  = push_valid & push_ready & ~flush;
  assign pop_fire   = not_empty & pop_ready & ~flush;

  // A faulting fetch must never reach Decode as a real instruction, so its word becomes a NOP.
  assign push_entry.pc    = push_pc;
  assign push_entry.instr = (push_exc != 5'd0) ? 32'h0 : push_instr;
  assign push_entry.exc   = push_exc;
  assign push_entry.bd    = push_bd;

`ifdef FQ_BYPASS_EN
  // Empty queue: the incoming word is offered to Decode directly; it is stored only if Decode stalls.
  assign byp   = ~not_empty & push_valid & ~flush;
  assign wr_en = push_fire & ~(byp & pop_ready);
`else
  assign byp   = 1'b0;
  assign wr_en = push_fire;
`endif

  assign pop_valid = not_empty | byp;

  // Head presentation: stored head when occupied, otherwise all-zero NOP (or the bypassed word).
  always_comb begin
    pop_pc    = 32'h0;
    pop_instr = 32'h0;
    pop_exc   = 5'd0;
    pop_bd    = 1'b0;
    if (not_empty) begin
      pop_pc    = mem[rd_ptr].pc;
      pop_instr = mem[rd_ptr].instr;
      pop_exc   = mem[rd_ptr].exc;
      pop_bd    = mem[rd_ptr].bd;
    end
`ifdef FQ_BYPASS_EN
    else if (byp) begin
      pop_pc    = push_entry.pc;
      pop_instr = push_entry.instr;
      pop_exc   = push_entry.exc;
      pop_bd    = push_entry.bd;
    end
`endif
  end

  // Storage array is deliberately left unreset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointer and occupancy state; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !pop_fire) begin
        count <= count + 1'b1;
      end else if (!wr_en && pop_fire) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
